// File: rtl/si5338_config_sequencer.sv
// SI5338B register-table sequencer: walks a ROM table, issues I2C register writes and masked RMWs.
// Define SEQ_VERIFY_EN to read back every written register and compare under the entry mask.
module si5338_config_sequencer #(
  parameter logic [6:0] DEV_ADR     = 7'b1110000,
  parameter int         NUM_ENTRIES = 64,
  parameter int         IDX_W       = 6,
  parameter int         MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [23:0]      rom_data,
  output logic             i2c_req_valid,
  input  logic             i2c_req_ready,
  output logic             i2c_req_rw,
  output logic [6:0]       i2c_req_dev,
  output logic [7:0]       i2c_req_reg,
  output logic [7:0]       i2c_req_wdata,
  input  logic             i2c_rsp_valid,
  input  logic             i2c_rsp_nack,
  input  logic [7:0]       i2c_rsp_rdata
);

  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LATCH, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT,
`ifdef SEQ_VERIFY_EN
    S_VF_REQ, S_VF_WAIT,
`endif
    S_NEXT, S_DONE, S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       mask_q, mask_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic             vld_q, vld_d;
  logic             rw_q, rw_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
      vld_q     <= 1'b0;
      rw_q      <= 1'b0;
      reg_q     <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
      vld_q     <= vld_d;
      rw_q      <= rw_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    data_d    = data_q;
    mask_d    = mask_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    vld_d     = vld_q;
    rw_d      = rw_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    fail      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          retry_d = '0;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        reg_d  = rom_data[23:16];
        data_d = rom_data[15:8];
        mask_d = rom_data[7:0];
        if (rom_data[7:0] == 8'hFF) begin
          vld_d   = 1'b1;
          rw_d    = 1'b0;
          wdata_d = rom_data[15:8];
          state_d = S_WR_REQ;
        end else if (rom_data[7:0] == 8'h00) begin
          // reg FF with an empty mask terminates the table; other empty masks are skips
          if (rom_data[23:16] == 8'hFF) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          vld_d   = 1'b1;
          rw_d    = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (i2c_req_ready) begin
          vld_d   = 1'b0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (i2c_rsp_valid) begin
          if (i2c_rsp_nack) begin
            fail = 1'b1;
          end else begin
            wdata_d = (i2c_rsp_rdata & ~mask_q) | (data_q & mask_q);
            vld_d   = 1'b1;
            rw_d    = 1'b0;
            state_d = S_WR_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (i2c_req_ready) begin
          vld_d   = 1'b0;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (i2c_rsp_valid) begin
          if (i2c_rsp_nack) begin
            fail = 1'b1;
          end else begin
`ifdef SEQ_VERIFY_EN
            vld_d   = 1'b1;
            rw_d    = 1'b1;
            state_d = S_VF_REQ;
`else
            state_d = S_NEXT;
`endif
          end
        end
      end
`ifdef SEQ_VERIFY_EN
      S_VF_REQ: begin
        if (i2c_req_ready) begin
          vld_d   = 1'b0;
          state_d = S_VF_WAIT;
        end
      end
      S_VF_WAIT: begin
        if (i2c_rsp_valid) begin
          if (i2c_rsp_nack || ((i2c_rsp_rdata & mask_q) != (data_q & mask_q))) fail = 1'b1;
          else state_d = S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        retry_d = '0;
        if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a failed attempt restarts the same entry from the ROM fetch
    if (fail) begin
      if (retry_q < RTY_W'(MAX_RETRY)) begin
        retry_d = retry_q + RTY_W'(1);
        state_d = S_FETCH;
      end else begin
        error_d   = 1'b1;
        err_idx_d = idx_q;
        state_d   = S_ERROR;
      end
    end
  end

  assign busy          = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done          = done_q;
  assign error         = error_q;
  assign err_index     = err_idx_q;
  assign rom_addr      = idx_q;
  assign i2c_req_valid = vld_q;
  assign i2c_req_rw    = rw_q;
  assign i2c_req_dev   = DEV_ADR;
  assign i2c_req_reg   = reg_q;
  assign i2c_req_wdata = wdata_q;

endmodule

// File: doc/si5338_config_sequencer.md
# si5338_config_sequencer

Register-table sequencer that configures the SI5338B clock generator on the FMC424 board over I2C. It walks a register table held in an external ROM and issues register-level read and write requests to the shared byte-level I2C master. It applies masked read-modify-write where the table requires it, retries NACKed entries and reports completion or failure to the board bring-up logic.

## Interface
Parameters:
- DEV_ADR, 7'b1110000, 7-bit I2C address of the SI5338B.
- NUM_ENTRIES, 64, number of table entries (2..256).
- IDX_W, 6, index width; must equal ceil(log2(NUM_ENTRIES)).
- MAX_RETRY, 3, extra attempts per entry after a failure (0 = no retry).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a table run.
- busy  out  1  high from the cycle after start is accepted until DONE or ERROR.
- done  out  1  level; table completed.
- error  out  1  level; entry failed after all retries.
- err_index  out  IDX_W  index of the failing entry (valid while error=1).
- rom_addr  out  IDX_W  table index; ROM output is valid 1 cycle later.
- rom_data  in  24  entry {reg[23:16], data[15:8], mask[7:0]}.
- i2c_req_valid  out  1  request valid.
- i2c_req_ready  in  1  master accepts request.
- i2c_req_rw  out  1  1 = read, 0 = write.
- i2c_req_dev  out  7  always DEV_ADR.
- i2c_req_reg  out  8  register address.
- i2c_req_wdata  out  8  write data.
- i2c_rsp_valid  in  1  one pulse per accepted request.
- i2c_rsp_nack  in  1  qualified by rsp_valid; transaction NACKed.
- i2c_rsp_rdata  in  8  qualified by rsp_valid; read data.

## Operation
- States: IDLE, FETCH, LATCH, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, VF_REQ, VF_WAIT, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + start: clear done, error and the retry counter; set idx=0; go to FETCH.
- start is ignored in any other state.
- FETCH: rom_addr=idx. LATCH captures rom_data into the entry register and decodes it:
  - mask=8'hFF → WR_REQ, write data.
  - mask=8'h00, reg=8'hFF → terminator, go to DONE.
  - mask=8'h00, any other reg → skip, go to NEXT with no I2C traffic.
  - any other mask → RD_REQ (read-modify-write).
- RD_REQ/RD_WAIT: read reg and capture rdata as old. Then WR_REQ writes (old & ~mask) | (data & mask).
- WR_WAIT done with no NACK → NEXT (or VF_REQ when verify is compiled in).
- Any NACK, or a verify mismatch, while retry < MAX_RETRY: retry++ and restart the entry at FETCH. Otherwise go to ERROR with err_index=idx.
- NEXT: clear retry. If idx==NUM_ENTRIES-1 → DONE, else idx++ → FETCH.
- i2c_rsp_valid is ignored outside *_WAIT states.

## Timing
- Reset values: busy=0, done=0, error=0, err_index=0, rom_addr=0, i2c_req_valid=0, i2c_req_rw=0, i2c_req_reg=0, i2c_req_wdata=0. State is IDLE.
- Start latency: start sampled at edge E0 → FETCH → LATCH → i2c_req_valid high in the cycle after E2.
- Request handshake:
  - All req fields are registered and held stable while valid && !ready.
  - Transfer occurs on the edge where valid && ready; valid is low the next cycle.
  - At most one request is outstanding.
- Response latency is unbounded; the sequencer waits in *_WAIT indefinitely (the master owns timeouts).
- rsp_valid in the same cycle the sequencer enters a *_WAIT state is accepted.
- Skip entries cost 3 cycles (FETCH, LATCH, NEXT).
- done and error rise together with busy falling.
- rst mid-transaction drops i2c_req_valid on the next edge. The I2C master shares rst, so it is reset in the same cycle.

## Configuration
- SEQ_VERIFY_EN defined:
  - After every successful write, VF_REQ/VF_WAIT reads the register back.
  - Pass requires (rdata & mask) == (data & mask); mask=FF compares the full byte.
  - A mismatch is treated exactly like a NACK (retry/ERROR).
- SEQ_VERIFY_EN undefined: VF states are absent and WR_WAIT goes directly to NEXT.

## Test plan
- Table {0x10,0xA5,0xFF}, {0xFF,0x00,0x00}, start → one write reg 0x10 data 0xA5 dev 0x70; done=1 after the terminator; busy low.
- RMW entry {0x20,0x0C,0x0F}, model returns rdata 0xF3 → read 0x20, then write 0xFC; done=1.
- Skip entry {0x30,0x00,0x00} between two writes → no request for 0x30; both writes issued in order.
- NACK on every attempt of entry 5, MAX_RETRY=3 → exactly 4 write attempts; error=1, err_index=5, done=0. A later start restarts from idx 0.
- Hold i2c_req_ready low 10 cycles, then assert rst mid-WR_WAIT → fields stable while stalled; all outputs at reset values 1 cycle after rst; start afterwards completes normally.
- With SEQ_VERIFY_EN, write 0x55 to reg 0x40 and read back 0x54 → treated as failure and the entry is retried; readback 0x55 → pass.
